// File: rtl/avr_irq_pkg.sv
// Shared definitions for the AVR interrupt controller: register offsets, FSM states, ISTAT layout.
// The optional round-robin arbitration is enabled by defining IRQ_RR_EN.
package avr_irq_pkg;

  localparam logic [1:0] REG_IEN   = 2'd0;
  localparam logic [1:0] REG_IPEND = 2'd1;
  localparam logic [1:0] REG_IMODE = 2'd2;
  localparam logic [1:0] REG_ISTAT = 2'd3;

  localparam int ISTAT_FLAG_BIT = 7;
  localparam int ISTAT_PTR_LSB  = 4;
  localparam int PTR_W          = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } irq_state_e;

  // Line index following cur, wrapping back to 0 at nirq.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] cur,
                                               input int unsigned nirq);
    logic [PTR_W:0] inc;
    inc = {1'b0, cur} + 4'd1;
    return (inc >= 4'(nirq)) ? '0 : inc[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/avr_irq_pick.sv
// Combinational winner select: the first requesting line found when scanning
// upward from ptr (wrapping at NIRQ). With ptr tied to 0 this is fixed priority.
module avr_irq_pick
  import avr_irq_pkg::*;
#(
  parameter int NIRQ = 4,
  parameter int VW   = 2
) (
  input  logic [NIRQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [VW-1:0]    vect
);

  always_comb begin
    int idx;
    any  = 1'b0;
    vect = '0;
    idx  = 0;
    for (int k = 0; k < NIRQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NIRQ) idx = idx - NIRQ;
      if (!any && req[idx]) begin
        any  = 1'b1;
        vect = VW'(idx);
      end
    end
  end

endmodule

// File: rtl/avr_irq_ctrl.sv
// AVR interrupt controller: pending latches, enable mask, edge/level mode and a
// vector handshake FSM toward avr_core. Define IRQ_RR_EN for round-robin arbitration.
module avr_irq_ctrl
  import avr_irq_pkg::*;
#(
  parameter int NIRQ = 4,
  parameter int VW   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            io_re,
  input  logic            io_we,
  input  logic [1:0]      io_a,
  input  logic [7:0]      io_di,
  output logic [7:0]      io_do,
  input  logic [NIRQ-1:0] irq_in,
  output logic            iflag,
  output logic [VW-1:0]   ivect,
  input  logic            ieack,
  input  logic [VW-1:0]   ieack_vect
);

  logic [NIRQ-1:0] ien_q, ien_d;
  logic [NIRQ-1:0] ipend_q, ipend_d;
  logic [NIRQ-1:0] imode_q, imode_d;
  logic [NIRQ-1:0] prev_q, prev_d;
  logic [NIRQ-1:0] w1c, ack_clr;

  irq_state_e      state_q, state_d;
  logic            iflag_q, iflag_d;
  logic [VW-1:0]   cur_vect_q, cur_vect_d;
  logic [PTR_W-1:0] rr_ptr;

  logic            ack_hit;
  logic            pick_any;
  logic [VW-1:0]   pick_vect;

  // Reads have no side effects; io_re only qualifies the bus transfer upstream.
  logic unused_inputs;
  assign unused_inputs = ^{io_re, io_di};

  assign ack_hit = (state_q == ST_ACTIVE) && ieack && (ieack_vect == cur_vect_q);

  always_comb begin
    ien_d   = ien_q;
    imode_d = imode_q;
    w1c     = '0;
    ack_clr = '0;
    prev_d  = irq_in;
    ipend_d = '0;
    if (io_we) begin
      case (io_a)
        REG_IEN:   ien_d   = io_di[NIRQ-1:0];
        REG_IPEND: w1c     = io_di[NIRQ-1:0];
        REG_IMODE: imode_d = io_di[NIRQ-1:0];
        default:   ;
      endcase
    end
    if (ack_hit && imode_q[cur_vect_q]) ack_clr[cur_vect_q] = 1'b1;
    // A new edge wins over a clear arriving in the same cycle.
    for (int i = 0; i < NIRQ; i++) begin
      if (imode_q[i])
        ipend_d[i] = (irq_in[i] & ~prev_q[i]) | (ipend_q[i] & ~(w1c[i] | ack_clr[i]));
      else
        ipend_d[i] = irq_in[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ien_q   <= '0;
      ipend_q <= '0;
      imode_q <= '0;
      prev_q  <= '0;
    end else begin
      ien_q   <= ien_d;
      ipend_q <= ipend_d;
      imode_q <= imode_d;
      prev_q  <= prev_d;
    end
  end

  avr_irq_pick #(
    .NIRQ (NIRQ),
    .VW   (VW)
  ) u_pick (
    .req  (ipend_q & ien_q),
    .ptr  (rr_ptr),
    .any  (pick_any),
    .vect (pick_vect)
  );

  // The ACTIVE drop test looks at next-cycle pending/enable so a W1C or
  // IEN write takes iflag down on the following cycle.
  always_comb begin
    state_d    = state_q;
    iflag_d    = iflag_q;
    cur_vect_d = cur_vect_q;
    case (state_q)
      ST_IDLE: begin
        iflag_d = 1'b0;
        if (pick_any) begin
          state_d    = ST_ACTIVE;
          iflag_d    = 1'b1;
          cur_vect_d = pick_vect;
        end
      end
      ST_ACTIVE: begin
        if (ack_hit) begin
          state_d = ST_HOLD;
          iflag_d = 1'b0;
        end else if (!(ipend_d[cur_vect_q] && ien_d[cur_vect_q])) begin
          state_d = ST_IDLE;
          iflag_d = 1'b0;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        iflag_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        iflag_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      iflag_q    <= 1'b0;
      cur_vect_q <= '0;
    end else begin
      state_q    <= state_d;
      iflag_q    <= iflag_d;
      cur_vect_q <= cur_vect_d;
    end
  end

`ifdef IRQ_RR_EN
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ack_hit) rr_ptr_d = rr_next(PTR_W'(cur_vect_q), NIRQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = '0;
`endif

  always_comb begin
    io_do = 8'h00;
    case (io_a)
      REG_IEN:   io_do[NIRQ-1:0] = ien_q;
      REG_IPEND: io_do[NIRQ-1:0] = ipend_q;
      REG_IMODE: io_do[NIRQ-1:0] = imode_q;
      default: begin
        io_do[ISTAT_FLAG_BIT]            = iflag_q;
        io_do[ISTAT_PTR_LSB +: PTR_W]    = rr_ptr;
        io_do[VW-1:0]                    = cur_vect_q;
      end
    endcase
  end

  assign iflag = iflag_q;
  assign ivect = cur_vect_q;

endmodule

// File: tb/tb_avr_irq_ctrl.sv
// Bench for avr_irq_ctrl: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_avr_irq_ctrl;
  localparam int NIRQ = 4;
  localparam int VW   = 2;
  localparam bit [7:0] MASK = 8'h0F;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            io_re = 1'b0;
  logic            io_we = 1'b0;
  logic [1:0]      io_a = 2'd0;
  logic [7:0]      io_di = 8'h00;
  logic [7:0]      io_do;
  logic [NIRQ-1:0] irq_in = '0;
  logic            iflag;
  logic [VW-1:0]   ivect;
  logic            ieack = 1'b0;
  logic [VW-1:0]   ieack_vect = '0;

  int n_tests = 0;
  int n_fail  = 0;

  avr_irq_ctrl #(.NIRQ(NIRQ), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n), .io_re(io_re), .io_we(io_we), .io_a(io_a),
    .io_di(io_di), .io_do(io_do), .irq_in(irq_in), .iflag(iflag),
    .ivect(ivect), .ieack(ieack), .ieack_vect(ieack_vect)
  );

  always #5 clk = ~clk;

  // Behavioural model: register contents plus "serving a vector" / "in hold-off" flags.
  bit [7:0] m_ien, m_pend, m_mode, m_prev;
  bit       m_flag, m_hold;
  int       m_vect, m_ptr;

  task automatic model_reset();
    m_ien = 0; m_pend = 0; m_mode = 0; m_prev = 0;
    m_flag = 0; m_hold = 0; m_vect = 0; m_ptr = 0;
  endtask

  function automatic int m_pick(input bit [7:0] req);
    for (int k = 0; k < NIRQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NIRQ;
      if (req[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic bit [7:0] m_read(input bit [1:0] a);
    case (a)
      2'd0:    return m_ien;
      2'd1:    return m_pend;
      2'd2:    return m_mode;
      default: return {m_flag, 3'(m_ptr), 2'b00, 2'(m_vect)};
    endcase
  endfunction

  task automatic model_edge();
    bit [7:0] w1c, ack_clr, np, nen, nmode;
    bit ack_ok;
    w1c   = (io_we && io_a == 2'd1) ? (io_di & MASK) : 8'h00;
    nen   = (io_we && io_a == 2'd0) ? (io_di & MASK) : m_ien;
    nmode = (io_we && io_a == 2'd2) ? (io_di & MASK) : m_mode;
    ack_ok  = m_flag && ieack && (int'(ieack_vect) == m_vect);
    ack_clr = (ack_ok && m_mode[m_vect]) ? (8'd1 << m_vect) : 8'h00;
    np = 8'h00;
    for (int i = 0; i < NIRQ; i++) begin
      if (m_mode[i]) np[i] = (irq_in[i] && !m_prev[i]) || (m_pend[i] && !w1c[i] && !ack_clr[i]);
      else           np[i] = irq_in[i];
    end
    if (m_hold) m_hold = 1'b0;
    else if (m_flag) begin
      if (ack_ok) begin
        m_flag = 1'b0;
        m_hold = 1'b1;
`ifdef IRQ_RR_EN
        m_ptr = (m_vect + 1) % NIRQ;
`endif
      end else if (!(np[m_vect] && nen[m_vect])) m_flag = 1'b0;
    end else if ((m_pend & m_ien) != 8'h00) begin
      m_flag = 1'b1;
      m_vect = m_pick(m_pend & m_ien);
    end
    m_pend = np; m_ien = nen; m_mode = nmode; m_prev = 8'(irq_in);
  endtask

  task automatic tick();
    if (rst_n) model_edge(); else model_reset();
    @(posedge clk); #1;
  endtask

  task automatic wr(input bit [1:0] a, input bit [7:0] d);
    io_we = 1'b1; io_a = a; io_di = d;
    tick();
    io_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_tests++; if (iflag !== 1'b0 || ivect !== 2'd0) begin n_fail++; $display("FAIL reset_out: iflag=%b ivect=%0d want 0/0", iflag, ivect); end
    for (int a = 0; a < 4; a++) begin
      io_a = 2'(a); #1;
      n_tests++; if (io_do !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d: got %02h want 00", a, io_do); end
    end
    rst_n = 1'b1;
    tick();
    n_tests++; if (iflag !== 1'b0 || ivect !== 2'd0) begin n_fail++; $display("FAIL release_out: iflag=%b ivect=%0d want 0/0", iflag, ivect); end
    io_a = 2'd3; #1;
    n_tests++; if (io_do !== 8'h00) begin n_fail++; $display("FAIL release_istat: got %02h want 00", io_do); end
  endtask

  task automatic test_priority();
    wr(2'd0, 8'h0F); wr(2'd2, 8'h0F);
    for (int rep = 0; rep < 2; rep++) begin
      irq_in = 4'b1010; tick(); irq_in = '0; tick();
      n_tests++; if (iflag !== 1'b1 || ivect !== 2'd1) begin n_fail++; $display("FAIL prio_first%0d: iflag=%b ivect=%0d want 1/1", rep, iflag, ivect); end
      io_a = 2'd3; #1;
      n_tests++; if (io_do !== 8'h81) begin n_fail++; $display("FAIL prio_istat%0d: got %02h want 81", rep, io_do); end
      ieack = 1'b1; ieack_vect = 2'd1; tick(); ieack = 1'b0;
      n_tests++; if (iflag !== 1'b0) begin n_fail++; $display("FAIL prio_ack_drop%0d: iflag=%b want 0", rep, iflag); end
      tick();
      n_tests++; if (iflag !== 1'b0) begin n_fail++; $display("FAIL prio_hold%0d: iflag=%b want 0", rep, iflag); end
      tick();
      n_tests++; if (iflag !== 1'b1 || ivect !== 2'd3) begin n_fail++; $display("FAIL prio_second%0d: iflag=%b ivect=%0d want 1/3", rep, iflag, ivect); end
      ieack = 1'b1; ieack_vect = 2'd3; tick(); ieack = 1'b0;
      tick(); tick();
      io_a = 2'd3; #1;
      n_tests++; if (io_do !== 8'h03) begin n_fail++; $display("FAIL prio_idle_istat%0d: got %02h want 03", rep, io_do); end
    end
  endtask

  task automatic test_edge();
    wr(2'd0, 8'h0F); wr(2'd2, 8'h0F);
    irq_in = 4'b0100; tick(); irq_in = '0;
    io_a = 2'd1; #1;
    n_tests++; if (io_do !== 8'h04) begin n_fail++; $display("FAIL edge_ipend: got %02h want 04", io_do); end
    n_tests++; if (iflag !== 1'b0) begin n_fail++; $display("FAIL edge_early: iflag=%b want 0", iflag); end
    tick();
    n_tests++; if (iflag !== 1'b1 || ivect !== 2'd2) begin n_fail++; $display("FAIL edge_req: iflag=%b ivect=%0d want 1/2", iflag, ivect); end
    ieack = 1'b1; ieack_vect = 2'd2; tick(); ieack = 1'b0;
    n_tests++; if (iflag !== 1'b0) begin n_fail++; $display("FAIL edge_ack_drop: iflag=%b want 0", iflag); end
    io_a = 2'd1; #1;
    n_tests++; if (io_do !== 8'h00) begin n_fail++; $display("FAIL edge_ack_clr: got %02h want 00", io_do); end
    tick(); tick();
    n_tests++; if (iflag !== 1'b0) begin n_fail++; $display("FAIL edge_quiet: iflag=%b want 0", iflag); end
  endtask

  task automatic test_level();
    wr(2'd2, 8'h00);
    irq_in = 4'b0001; tick(); tick();
    n_tests++; if (iflag !== 1'b1 || ivect !== 2'd0) begin n_fail++; $display("FAIL level_req: iflag=%b ivect=%0d want 1/0", iflag, ivect); end
    ieack = 1'b1; ieack_vect = 2'd0; tick(); ieack = 1'b0;
    n_tests++; if (iflag !== 1'b0) begin n_fail++; $display("FAIL level_hold: iflag=%b want 0", iflag); end
    tick();
    n_tests++; if (iflag !== 1'b0) begin n_fail++; $display("FAIL level_gap: iflag=%b want 0", iflag); end
    tick();
    n_tests++; if (iflag !== 1'b1 || ivect !== 2'd0) begin n_fail++; $display("FAIL level_rearm: iflag=%b ivect=%0d want 1/0", iflag, ivect); end
    irq_in = '0; tick();
    n_tests++; if (iflag !== 1'b0) begin n_fail++; $display("FAIL level_release: iflag=%b want 0", iflag); end
    tick(); tick();
    io_a = 2'd1; #1;
    n_tests++; if (iflag !== 1'b0 || io_do !== 8'h00) begin n_fail++; $display("FAIL level_idle: iflag=%b ipend=%02h want 0/00", iflag, io_do); end
  endtask

  task automatic test_w1c_drop();
    wr(2'd2, 8'h0F);
    irq_in = 4'b0100; tick(); irq_in = '0; tick();
    n_tests++; if (iflag !== 1'b1 || ivect !== 2'd2) begin n_fail++; $display("FAIL w1c_req: iflag=%b ivect=%0d want 1/2", iflag, ivect); end
    wr(2'd1, 8'h04);
    io_a = 2'd1; #1;
    n_tests++; if (iflag !== 1'b0 || io_do !== 8'h00) begin n_fail++; $display("FAIL w1c_drop: iflag=%b ipend=%02h want 0/00", iflag, io_do); end
    tick();
    n_tests++; if (iflag !== 1'b0) begin n_fail++; $display("FAIL w1c_idle: iflag=%b want 0", iflag); end
    irq_in = 4'b0100; tick(); irq_in = '0; tick();
    irq_in = 4'b0100; io_we = 1'b1; io_a = 2'd1; io_di = 8'h04; tick();
    io_we = 1'b0; irq_in = '0;
    io_a = 2'd1; #1;
    n_tests++; if (io_do !== 8'h04 || iflag !== 1'b1) begin n_fail++; $display("FAIL w1c_set_wins: ipend=%02h iflag=%b want 04/1", io_do, iflag); end
    ieack = 1'b1; ieack_vect = 2'd2; tick(); ieack = 1'b0;
    io_a = 2'd1; #1;
    n_tests++; if (io_do !== 8'h00) begin n_fail++; $display("FAIL w1c_ack_clr: got %02h want 00", io_do); end
    tick(); tick();
  endtask

  task automatic test_wrong_ack();
    irq_in = 4'b0100; tick(); irq_in = '0; tick();
    ieack = 1'b1; ieack_vect = 2'd1; tick(); ieack = 1'b0;
    io_a = 2'd1; #1;
    n_tests++; if (iflag !== 1'b1 || ivect !== 2'd2 || io_do !== 8'h04) begin n_fail++; $display("FAIL wrong_ack: iflag=%b ivect=%0d ipend=%02h want 1/2/04", iflag, ivect, io_do); end
    ieack = 1'b1; ieack_vect = 2'd2; tick(); ieack = 1'b0;
    n_tests++; if (iflag !== 1'b0) begin n_fail++; $display("FAIL wrong_ack_retire: iflag=%b want 0", iflag); end
    tick(); tick();
  endtask

  task automatic test_ien_drop();
    irq_in = 4'b0010; tick(); irq_in = '0; tick();
    wr(2'd0, 8'h0D);
    io_a = 2'd1; #1;
    n_tests++; if (iflag !== 1'b0 || io_do !== 8'h02) begin n_fail++; $display("FAIL ien_drop: iflag=%b ipend=%02h want 0/02", iflag, io_do); end
    tick();
    n_tests++; if (iflag !== 1'b0) begin n_fail++; $display("FAIL ien_masked: iflag=%b want 0", iflag); end
    wr(2'd0, 8'h0F); tick();
    n_tests++; if (iflag !== 1'b1 || ivect !== 2'd1) begin n_fail++; $display("FAIL ien_reenable: iflag=%b ivect=%0d want 1/1", iflag, ivect); end
    ieack = 1'b1; ieack_vect = 2'd1; tick(); ieack = 1'b0;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    irq_in = 4'b0100; tick(); irq_in = '0; tick();
    #2 rst_n = 1'b0; #1;
    io_a = 2'd0; #0;
    n_tests++; if (iflag !== 1'b0 || ivect !== 2'd0 || io_do !== 8'h00) begin n_fail++; $display("FAIL async_reset: iflag=%b ivect=%0d ien=%02h want 0/0/00", iflag, ivect, io_do); end
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    wr(2'd0, 8'h0F);
    wr(2'd2, 8'($urandom));
    for (int c = 0; c < 500; c++) begin
      bit [1:0] ra;
      n_tests++; if (iflag !== m_flag || ivect !== VW'(m_vect)) begin n_fail++; $display("FAIL rand_out c%0d: iflag=%b ivect=%0d want %b/%0d", c, iflag, ivect, m_flag, m_vect); end
      ra = 2'($urandom_range(0, 3));
      io_re = 1'b1; io_a = ra; #1;
      n_tests++; if (io_do !== m_read(ra)) begin n_fail++; $display("FAIL rand_reg%0d c%0d: got %02h want %02h", ra, c, io_do, m_read(ra)); end
      io_re = 1'b0;
      irq_in = irq_in ^ 4'($urandom & $urandom);
      io_we = ($urandom_range(0, 7) == 0);
      if (io_we) begin io_a = 2'($urandom_range(0, 3)); io_di = 8'($urandom); end
      ieack = (m_flag && $urandom_range(0, 2) == 0) || ($urandom_range(0, 15) == 0);
      ieack_vect = ($urandom_range(0, 3) == 0) ? VW'($urandom) : VW'(m_vect);
      tick();
      io_we = 1'b0; ieack = 1'b0;
    end
    irq_in = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_priority();
    test_edge();
    test_level();
    test_w1c_drop();
    test_wrong_ack();
    test_ien_drop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
